trigger_scheduler: RTL and testbench

- Controller that sequences trigger generation for the acquisition path.
- Selects one trigger source: external input, encoder step or software strobe.
- Applies a programmable delay, pulse width and hold-off to the selected source, and counts accepted and dropped events.
- Drives the single o_trigger line consumed downstream; it replaces direct wiring of ext/encoder inputs to the trigger output.

---
 rtl/trigger_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_trigger_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_scheduler.sv
// -----------------------------------------------------------------------------
// trigger_scheduler
//
// Sequences trigger generation for the acquisition path. One of three event
// sources is selected: the external input, the encoder step or the software
// strobe. Each accepted event is turned into a delayed pulse of programmable
// width, followed by a hold-off window. Events that arrive while the scheduler
// is busy are dropped and counted. A burst length of 0 runs continuously;
// otherwise the scheduler stops after that many triggers and pulses o_done.
//
// Ports
//   i_clk               system clock
//   i_aresetn           asynchronous active-low reset
//   ext_input           external trigger (asynchronous, synchronized here)
//   encoder_step_input  encoder step (asynchronous, synchronized here)
//   i_sw_trig           software trigger, synchronous one-cycle pulse
//   i_src_sel           0 ext, 1 encoder, 2 software, 3 none
//   i_arm               level: high runs, low aborts to idle
//   i_delay             cycles from event to trigger rise
//   i_width             trigger high time in cycles (0 behaves as 1)
//   i_holdoff           dead cycles after the trigger falls
//   i_burst             triggers per arm (0 = continuous)
//   o_trigger           registered trigger pulse
//   o_busy              high whenever the scheduler is not idle
//   o_done              one-cycle pulse when a burst completes
//   o_trig_cnt          triggers issued since arm (wraps)
//   o_missed_cnt        events dropped since arm (saturates)
// -----------------------------------------------------------------------------
module trigger_scheduler #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_aresetn,
  input  logic          ext_input,
  input  logic          encoder_step_input,
  input  logic          i_sw_trig,
  input  logic [1:0]    i_src_sel,
  input  logic          i_arm,
  input  logic [DW-1:0] i_delay,
  input  logic [DW-1:0] i_width,
  input  logic [DW-1:0] i_holdoff,
  input  logic [CW-1:0] i_burst,
  output logic          o_trigger,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_trig_cnt,
  output logic [CW-1:0] o_missed_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    DELAY   = 3'd2,
    PULSE   = 3'd3,
    HOLDOFF = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          pulse_start;
  logic          missed_inc;
  logic          post_done;
  logic          evt;
  logic          rearm_block;

  logic          ext_p0, ext_p1, ext_p2, ext_evt_p2;
  logic          enc_p0, enc_p1, enc_p2, enc_evt_p2;

  logic [1:0]    cfg_src;
  logic [DW-1:0] cfg_delay, cfg_width, cfg_holdoff;
  logic [CW-1:0] cfg_burst;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Down-counter preload for a phase of length v; a zero length still
  // occupies one cycle.
  function automatic logic [DW-1:0] len_m1(input logic [DW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizers. Stage p2: previous level and the
  // registered rising-edge strobe, valid two cycles after the first sample.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ext_p0     <= 1'b0;
      ext_p1     <= 1'b0;
      ext_p2     <= 1'b0;
      ext_evt_p2 <= 1'b0;
      enc_p0     <= 1'b0;
      enc_p1     <= 1'b0;
      enc_p2     <= 1'b0;
      enc_evt_p2 <= 1'b0;
    end else begin
      ext_p0     <= ext_input;
      ext_p1     <= ext_p0;
      ext_p2     <= ext_p1;
      ext_evt_p2 <= ext_p1 & ~ext_p2;
      enc_p0     <= encoder_step_input;
      enc_p1     <= enc_p0;
      enc_p2     <= enc_p1;
      enc_evt_p2 <= enc_p1 & ~enc_p2;
    end
  end

  // Source selection uses the configuration latched at arm time. The
  // software strobe is already synchronous and bypasses the pipeline.
  always_comb begin
    evt = 1'b0;
    case (cfg_src)
      2'd0:    evt = ext_evt_p2;
      2'd1:    evt = enc_evt_p2;
      2'd2:    evt = i_sw_trig;
      default: evt = 1'b0;
    endcase
  end

  assign post_done = (cfg_burst != '0) && (o_trig_cnt == cfg_burst);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pulse_start = 1'b0;
    missed_inc  = 1'b0;
    if (state != IDLE && !i_arm) begin
      // Abort takes priority over any event in the same cycle.
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_arm && !rearm_block) state_nxt = WAIT;
        end
        WAIT: begin
          if (evt) begin
            if (cfg_delay != '0) begin
              state_nxt = DELAY;
              cnt_nxt   = cfg_delay - 1'b1;
            end else begin
              state_nxt   = PULSE;
              cnt_nxt     = len_m1(cfg_width);
              pulse_start = 1'b1;
            end
          end
        end
        DELAY: begin
          missed_inc = evt;
          if (cnt == '0) begin
            state_nxt   = PULSE;
            cnt_nxt     = len_m1(cfg_width);
            pulse_start = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        PULSE: begin
          missed_inc = evt;
          if (cnt == '0) begin
            if (cfg_holdoff != '0) begin
              state_nxt = HOLDOFF;
              cnt_nxt   = cfg_holdoff - 1'b1;
            end else begin
              state_nxt = post_done ? DONE : WAIT;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        HOLDOFF: begin
          missed_inc = evt;
          if (cnt == '0) begin
            state_nxt = post_done ? DONE : WAIT;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Stage p0 of the control path: state, counters, latched configuration and
  // outputs decoded from the next state so they leave straight from flops.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state        <= IDLE;
      cnt          <= '0;
      rearm_block  <= 1'b0;
      cfg_src      <= '0;
      cfg_delay    <= '0;
      cfg_width    <= '0;
      cfg_holdoff  <= '0;
      cfg_burst    <= '0;
      o_trig_cnt   <= '0;
      o_missed_cnt <= '0;
      o_trigger    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (state == IDLE && state_nxt == WAIT) begin
        cfg_src      <= i_src_sel;
        cfg_delay    <= i_delay;
        cfg_width    <= i_width;
        cfg_holdoff  <= i_holdoff;
        cfg_burst    <= i_burst;
        o_trig_cnt   <= '0;
        o_missed_cnt <= '0;
      end else begin
        if (pulse_start) o_trig_cnt <= o_trig_cnt + 1'b1;
        if (missed_inc)  o_missed_cnt <= sat_inc(o_missed_cnt);
      end

      // After a completed burst the arm level must drop before a new run.
      if (!i_arm) begin
        rearm_block <= 1'b0;
      end else if (state == DONE) begin
        rearm_block <= 1'b1;
      end

      o_trigger <= (state_nxt == PULSE);
      o_busy    <= (state_nxt != IDLE);
      o_done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_trigger_scheduler.sv
module tb_trigger_scheduler;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_aresetn = 1'b0;
  logic          ext_input = 1'b0;
  logic          encoder_step_input = 1'b0;
  logic          i_sw_trig = 1'b0;
  logic [1:0]    i_src_sel = '0;
  logic          i_arm = 1'b0;
  logic [DW-1:0] i_delay = '0;
  logic [DW-1:0] i_width = '0;
  logic [DW-1:0] i_holdoff = '0;
  logic [CW-1:0] i_burst = '0;
  logic          o_trigger, o_busy, o_done;
  logic [CW-1:0] o_trig_cnt, o_missed_cnt;

  trigger_scheduler #(.DW(DW), .CW(CW)) dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn), .ext_input(ext_input),
    .encoder_step_input(encoder_step_input), .i_sw_trig(i_sw_trig),
    .i_src_sel(i_src_sel), .i_arm(i_arm), .i_delay(i_delay),
    .i_width(i_width), .i_holdoff(i_holdoff), .i_burst(i_burst),
    .o_trigger(o_trigger), .o_busy(o_busy), .o_done(o_done),
    .o_trig_cnt(o_trig_cnt), .o_missed_cnt(o_missed_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a run is described by the edge at which an event was
  // accepted and the derived rise / fall / end-of-holdoff edges.
  int            cyc = 0;
  logic [4:0]    eh = '0, nh = '0;   // bit i = input level sampled i edges ago
  int            m_mode = 0;          // 0 idle, 1 armed, 2 done
  bit            m_block = 1'b0;
  bit            m_active = 1'b0;
  int            m_rise = 0, m_fall = 0, m_end = 0;
  logic [1:0]    m_src = '0;
  int            m_d = 0, m_w = 1, m_h = 0;
  logic [CW-1:0] m_burst = '0, m_trig = '0, m_missed = '0;
  logic [2*CW+2:0] obs, exp_v;

  function automatic void model_clear();
    eh = '0; nh = '0; m_mode = 0; m_block = 1'b0; m_active = 1'b0;
    m_src = '0; m_d = 0; m_w = 1; m_h = 0; m_burst = '0; m_trig = '0; m_missed = '0;
  endfunction

  task automatic tick();
    bit e;
    int prev;
    @(posedge i_clk);
    cyc++;
    if (!i_aresetn) begin
      model_clear();
    end else begin
      eh = {eh[3:0], ext_input};
      nh = {nh[3:0], encoder_step_input};
      case (m_src)
        2'd0:    e = eh[3] & ~eh[4];
        2'd1:    e = nh[3] & ~nh[4];
        2'd2:    e = i_sw_trig;
        default: e = 1'b0;
      endcase
      prev = m_mode;
      if (m_mode != 0 && !i_arm) begin
        m_mode = 0; m_active = 1'b0;
      end else if (m_mode == 0) begin
        if (i_arm && !m_block) begin
          m_mode = 1; m_active = 1'b0; m_trig = '0; m_missed = '0;
          m_src = i_src_sel; m_d = int'(i_delay);
          m_w = (i_width == '0) ? 1 : int'(i_width);
          m_h = int'(i_holdoff); m_burst = i_burst;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else if (m_active) begin
        if (e && m_missed != '1) m_missed++;
        if (cyc == m_rise) m_trig++;
        if (cyc == m_end) begin
          m_active = 1'b0;
          if (m_burst != '0 && m_trig == m_burst) m_mode = 2;
        end
      end else if (e) begin
        m_active = 1'b1;
        m_rise = cyc + m_d; m_fall = m_rise + m_w; m_end = m_fall + m_h;
        if (m_d == 0) m_trig++;
      end
      if (!i_arm) m_block = 1'b0;
      else if (prev == 2) m_block = 1'b1;
    end
    #1;
    obs = {o_trigger, o_busy, o_done, o_trig_cnt, o_missed_cnt};
    exp_v = {(m_mode == 1 && m_active && cyc >= m_rise && cyc < m_fall),
             (m_mode != 0), (m_mode == 2), m_trig, m_missed};
  endtask

  task automatic configure(input int src, input int d, input int w, input int h, input int b);
    i_src_sel = 2'(src); i_delay = DW'(d); i_width = DW'(w);
    i_holdoff = DW'(h); i_burst = CW'(b);
  endtask

  task automatic rearm(input int src, input int d, input int w, input int h, input int b);
    i_arm = 1'b0; tick();
    configure(src, d, w, h, b);
    i_arm = 1'b1; tick();
  endtask

  task automatic test_reset();
    i_aresetn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ext_input = k[0]; encoder_step_input = ~k[0]; i_sw_trig = k[0];
      i_arm = 1'b1; i_src_sel = k[1:0];
      tick();
      n_vec++;
      if (obs !== '0) begin
        n_err++; $display("FAIL reset cyc %0d: got %h required 0", cyc, obs);
      end
    end
    ext_input = 0; encoder_step_input = 0; i_sw_trig = 0; i_arm = 0; i_src_sel = 0;
    tick();
    i_aresetn = 1'b1;
    tick();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset_release: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_ext_basic();
    int rise, hi;
    rearm(0, 0, 1, 0, 0);
    ext_input = 1'b1; tick(); ext_input = 1'b0;
    rise = -1; hi = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ext_basic cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
      if (o_trigger) begin hi++; if (rise < 0) rise = k; end
    end
    n_vec++;
    if (rise !== 3 || hi !== 1 || o_trig_cnt !== CW'(1)) begin
      n_err++; $display("FAIL ext_latency: rise %0d high %0d cnt %0d required 3 1 1", rise, hi, o_trig_cnt);
    end
  endtask

  task automatic test_delay_width();
    int rise, hi;
    rearm(1, 5, 4, 0, 0);
    encoder_step_input = 1'b1; tick(); encoder_step_input = 1'b0;
    rise = -1; hi = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL delay_width cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
      if (o_trigger) begin hi++; if (rise < 0) rise = k; end
    end
    n_vec++;
    if (rise !== 8 || hi !== 4) begin
      n_err++; $display("FAIL delay_width_timing: rise %0d high %0d required 8 4", rise, hi);
    end
  endtask

  task automatic test_burst();
    int rises, dones;
    bit last;
    rearm(2, 0, 1, 10, 3);
    rises = 0; dones = 0; last = 1'b0;
    for (int k = 0; k < 52; k++) begin
      i_sw_trig = (k < 48) && (k % 4 == 0);
      tick();
      i_sw_trig = 1'b0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL burst cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
      if (o_trigger && !last) rises++;
      if (o_done) dones++;
      last = o_trigger;
    end
    n_vec++;
    if (rises !== 3 || dones !== 1 || o_missed_cnt !== CW'(6) || o_busy !== 1'b0 ||
        o_trig_cnt !== CW'(3)) begin
      n_err++;
      $display("FAIL burst_summary: trig %0d done %0d missed %0d busy %0b cnt %0d required 3 1 6 0 3",
               rises, dones, o_missed_cnt, o_busy, o_trig_cnt);
    end
  endtask

  task automatic test_masking();
    int seen;
    seen = 0;
    for (int pass = 0; pass < 2; pass++) begin
      rearm(pass == 0 ? 0 : 3, 0, 1, 0, 0);
      for (int k = 0; k < 16; k++) begin
        encoder_step_input = (k % 3 == 0) && (k < 12);
        i_sw_trig = (k % 2 == 0) && (k < 12);
        ext_input = (pass == 1) && (k % 4 == 0) && (k < 12);
        tick();
        n_vec++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL masking cyc %0d: got %h required %h", cyc, obs, exp_v);
        end
        if (o_trigger) seen++;
      end
      encoder_step_input = 0; i_sw_trig = 0; ext_input = 0;
      n_vec++;
      if (seen !== 0 || o_trig_cnt !== '0 || o_missed_cnt !== '0) begin
        n_err++; $display("FAIL masking_src%0d: trig %0d cnt %0d missed %0d required 0 0 0",
                          pass == 0 ? 0 : 3, seen, o_trig_cnt, o_missed_cnt);
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    rearm(0, 20, 1, 0, 0);
    ext_input = 1'b1; tick(); ext_input = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL abort_first cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
    end
    ext_input = 1'b1; tick(); ext_input = 1'b0;
    bad = 0;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (o_trigger || o_done) bad++;
    end
    i_arm = 1'b0;
    tick();
    n_vec++;
    if (obs !== exp_v || bad !== 0 || o_busy !== 1'b0 || o_trig_cnt !== CW'(1)) begin
      n_err++; $display("FAIL abort: got %h bad %0d required %h bad 0", obs, bad, exp_v);
    end
    configure(2, 0, 1, 0, 0);
    i_arm = 1'b1; tick();
    n_vec++;
    if (o_trig_cnt !== '0 || o_missed_cnt !== '0 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL abort_rearm: cnt %0d missed %0d busy %0b required 0 0 1",
                        o_trig_cnt, o_missed_cnt, o_busy);
    end
  endtask

  task automatic test_sat_wrap();
    rearm(2, 0, 1, 40, 0);
    for (int k = 0; k < 45; k++) begin
      i_sw_trig = 1'b1; tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL saturate cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
    end
    i_sw_trig = 1'b0;
    n_vec++;
    if (o_missed_cnt !== {CW{1'b1}}) begin
      n_err++; $display("FAIL missed_saturate: got %0d required %0d", o_missed_cnt, {CW{1'b1}});
    end
    rearm(2, 0, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      i_sw_trig = (k % 2 == 0); tick(); i_sw_trig = 1'b0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL wrap cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
    end
    tick();
    n_vec++;
    if (o_trig_cnt !== CW'(20) || o_missed_cnt !== '0) begin
      n_err++; $display("FAIL trig_wrap: cnt %0d missed %0d required %0d 0", o_trig_cnt, o_missed_cnt, CW'(20));
    end
  endtask

  task automatic test_async_reset();
    rearm(2, 0, 50, 0, 0);
    i_sw_trig = 1'b1; tick(); i_sw_trig = 1'b0;
    for (int k = 1; k < 20; k++) begin
      tick();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL pulse_run cyc %0d: got %h required %h", cyc, obs, exp_v);
      end
    end
    #3;
    i_aresetn = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (o_trigger !== 1'b0 || o_busy !== 1'b0 || o_trig_cnt !== '0) begin
      n_err++; $display("FAIL async_reset: trig %0b busy %0b cnt %0d required 0 0 0",
                        o_trigger, o_busy, o_trig_cnt);
    end
    i_arm = 1'b0;
    tick(); tick();
    i_aresetn = 1'b1;
    tick();
    n_vec++;
    if (obs !== exp_v || o_busy !== 1'b0) begin
      n_err++; $display("FAIL after_async_reset: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      rearm(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      for (int k = 0; k < 120; k++) begin
        ext_input = ($urandom_range(0, 3) == 0);
        encoder_step_input = ($urandom_range(0, 3) == 0);
        i_sw_trig = ($urandom_range(0, 5) == 0);
        i_arm = ($urandom_range(0, 40) != 0);
        if ($urandom_range(0, 9) == 0)
          configure(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        tick();
        n_vec++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL random run %0d cyc %0d: got %h required %h", run, cyc, obs, exp_v);
        end
      end
      ext_input = 0; encoder_step_input = 0; i_sw_trig = 0;
    end
  endtask

  initial begin
    test_reset();
    test_ext_basic();
    test_delay_width();
    test_burst();
    test_masking();
    test_abort();
    test_sat_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
